// File: rtl/debug_frame_rx_pkg.sv
// Shared constants and state encoding for the debug-link framers.
package debug_frame_rx_pkg;

    localparam int          DEBUG_FRAME_DATA_LEN = 4;
    localparam int          DEBUG_DATA_WIDTH     = 8;
    localparam logic [7:0]  SYNC_HI_BYTE         = 8'h5A;
    localparam logic [7:0]  SYNC_LO_BYTE         = 8'hA5;
    localparam logic [15:0] CRC16_POLY           = 16'h1021;
    localparam logic [15:0] CRC16_INIT           = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CMD,
        ST_DATA,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_HOLD
    } frame_rx_state_t;

endpackage

// File: rtl/debug_crc16_byte.sv
// CRC-16/CCITT-FALSE, one byte folded MSB-first; purely combinational.
module debug_crc16_byte
    import debug_frame_rx_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {data_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_o = crc_o[15] ? ((crc_o << 1) ^ CRC16_POLY) : (crc_o << 1);
        end
    end

endmodule

// File: rtl/debug_frame_rx.sv
// Debug UART receive framer: sync hunt, CRC-16 check, one-frame hold for the decoder.
// frame_valid rises 1 clk after the CRC low byte; bytes arriving during HOLD are dropped (overrun).
module debug_frame_rx
    import debug_frame_rx_pkg::*;
#(
    parameter int         DATA_LEN       = DEBUG_FRAME_DATA_LEN,
    parameter logic [7:0] SYNC_HI        = SYNC_HI_BYTE,
    parameter logic [7:0] SYNC_LO        = SYNC_LO_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TO_WIDTH       = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  frame_valid,
    output logic [7:0]            frame_cmd,
    output logic [8*DATA_LEN-1:0] frame_data,
    input  logic                  frame_ack,
    output logic                  crc_error,
    output logic                  timeout_error,
    output logic                  overrun,
    output logic                  busy
);

    localparam int DW = 8 * DATA_LEN;
    localparam int CW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    // Timeout fires on the idle clock that would bring the counter to TIMEOUT_CYCLES-1.
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0]       CNT_LAST = CW'(DATA_LEN - 1);

    frame_rx_state_t      state_q;
    logic [15:0]          crc_q;
    logic [15:0]          crc_d;
    logic [7:0]           crc_hi_q;
    logic [CW-1:0]        cnt_q;
    logic [TO_WIDTH-1:0]  to_q;
    logic [7:0]           frame_cmd_q;
    logic [DW-1:0]        frame_data_q;
    logic                 frame_valid_q;
    logic                 crc_error_q;
    logic                 timeout_error_q;
    logic                 overrun_q;
    logic                 in_frame;

    // The command byte always seeds a fresh CRC, so no explicit clear between frames.
    debug_crc16_byte u_crc (
        .crc_i  ((state_q == ST_CMD) ? CRC16_INIT : crc_q),
        .data_i (byte_in),
        .crc_o  (crc_d)
    );

    assign in_frame = (state_q != ST_IDLE) && (state_q != ST_HOLD);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q         <= ST_IDLE;
            crc_q           <= CRC16_INIT;
            crc_hi_q        <= 8'h00;
            cnt_q           <= '0;
            to_q            <= '0;
            frame_cmd_q     <= 8'h00;
            frame_data_q    <= '0;
            frame_valid_q   <= 1'b0;
            crc_error_q     <= 1'b0;
            timeout_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            crc_error_q     <= 1'b0;
            timeout_error_q <= 1'b0;
            overrun_q       <= 1'b0;

            if (byte_valid || !in_frame) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + TO_WIDTH'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (byte_valid && byte_in == SYNC_HI) state_q <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (byte_valid) begin
                        if (byte_in == SYNC_LO)      state_q <= ST_CMD;
                        else if (byte_in != SYNC_HI) state_q <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (byte_valid) begin
                        frame_cmd_q <= byte_in;
                        crc_q       <= crc_d;
                        cnt_q       <= '0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_valid) begin
                        frame_data_q <= (frame_data_q << 8) | DW'(byte_in);
                        crc_q        <= crc_d;
                        cnt_q        <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) state_q <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (byte_valid) begin
                        crc_hi_q <= byte_in;
                        state_q  <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (byte_valid) begin
                        if ({crc_hi_q, byte_in} == crc_q) begin
                            frame_valid_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end else begin
                            crc_error_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (byte_valid) overrun_q <= 1'b1;
                    if (frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A byte on the limit cycle wins over the timeout.
            if (in_frame && !byte_valid && to_q == TO_LIMIT) begin
                timeout_error_q <= 1'b1;
                state_q         <= ST_IDLE;
            end
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_data    = frame_data_q;
    assign crc_error     = crc_error_q;
    assign timeout_error = timeout_error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_frame_rx.sv
// Bench for debug_frame_rx: directed scenarios plus random frames against a bit-serial CRC model.
module tb_debug_frame_rx;

    localparam int DL = 8;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          byte_valid;
    logic [7:0]    byte_in;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [8*DL-1:0] frame_data;
    logic          frame_ack;
    logic          crc_error;
    logic          timeout_error;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    debug_frame_rx #(
        .DATA_LEN       (DL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .byte_valid    (byte_valid),
        .byte_in       (byte_in),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_data    (frame_data),
        .frame_ack     (frame_ack),
        .crc_error     (crc_error),
        .timeout_error (timeout_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event counters sampled on the falling edge.
    int   crc_cnt = 0, to_cnt = 0, ovr_cnt = 0, fv_cnt = 0;
    logic fv_prev = 1'b0;
    always @(negedge clk) begin
        if (crc_error)     crc_cnt++;
        if (timeout_error) to_cnt++;
        if (overrun)       ovr_cnt++;
        if (frame_valid && !fv_prev) fv_cnt++;
        fv_prev = frame_valid;
    end

    // Reference CRC: bit-serial LFSR over cmd followed by payload, MSB first.
    function automatic logic [15:0] ref_crc(input logic [7:0] cmd, input logic [63:0] data);
        logic [71:0] msg;
        logic [15:0] c;
        logic        fb;
        msg = {cmd, data};
        c   = 16'hFFFF;
        for (int i = 71; i >= 0; i--) begin
            fb = c[15] ^ msg[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic gap_byte(input logic [7:0] b, input int gmax);
        idle($urandom_range(gmax, 0));
        send_byte(b);
    endtask

    // Everything up to and including the CRC high byte.
    task automatic send_body(input logic [7:0] cmd, input logic [63:0] data,
                             input logic [7:0] hi, input int gmax);
        gap_byte(8'h5A, gmax);
        gap_byte(8'hA5, gmax);
        gap_byte(cmd, gmax);
        for (int i = DL - 1; i >= 0; i--) gap_byte(data[8*i +: 8], gmax);
        gap_byte(hi, gmax);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    localparam logic [63:0] KD = 64'h3233343536373839;

    initial begin
        int c0, t0, f0, o0;
        logic [7:0]  cmd;
        logic [63:0] data;
        logic [15:0] crc;
        logic        bad;

        sync_reset = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        frame_ack  = 1'b0;
        idle(2);
        check("reset_outs", {frame_valid, crc_error, timeout_error, overrun, busy}, 5'b0);
        check("reset_cmd", frame_cmd, 8'h00);
        check("reset_data", frame_data, 64'h0);
        sync_reset = 1'b0;
        tick();

        // Clean frame
        send_body(8'h31, KD, 8'h29, 0);
        check("clean_pre_fv", frame_valid, 1'b0);
        send_byte(8'hB1);
        check("clean_fv", frame_valid, 1'b1);
        check("clean_cmd", frame_cmd, 8'h31);
        check("clean_data", frame_data, KD);
        idle(3);
        check("clean_hold_fv", frame_valid, 1'b1);
        check("clean_hold_data", frame_data, KD);
        do_ack();
        check("clean_ack_fv", frame_valid, 1'b0);
        check("clean_ack_busy", busy, 1'b0);

        // Corrupt CRC
        c0 = crc_cnt; f0 = fv_cnt;
        send_body(8'h31, KD, 8'h29, 0);
        send_byte(8'hB0);
        check("bad_crc_pulse", crc_error, 1'b1);
        check("bad_crc_fv", frame_valid, 1'b0);
        check("bad_crc_busy", busy, 1'b0);
        tick();
        check("bad_crc_pulse_end", crc_error, 1'b0);
        check("bad_crc_count", crc_cnt - c0, 1);
        check("bad_crc_no_frame", fv_cnt - f0, 0);

        // Resync on repeated SYNC_HI
        f0 = fv_cnt;
        send_byte(8'h5A);
        send_body(8'h31, KD, 8'h29, 0);
        send_byte(8'hB1);
        check("resync_fv", frame_valid, 1'b1);
        check("resync_data", frame_data, KD);
        do_ack();
        send_byte(8'h5A);
        send_byte(8'h00);
        check("badsync_idle", busy, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h31);
        for (int i = DL - 1; i >= 0; i--) send_byte(KD[8*i +: 8]);
        send_byte(8'h29);
        send_byte(8'hB1);
        idle(2);
        check("badsync_frames", fv_cnt - f0, 1);
        check("badsync_fv", frame_valid, 1'b0);

        // Inter-byte timeout
        t0 = to_cnt;
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h31);
        idle(TO - 2);
        check("to_not_yet", timeout_error, 1'b0);
        check("to_busy_pre", busy, 1'b1);
        tick();
        check("to_pulse", timeout_error, 1'b1);
        check("to_busy_post", busy, 1'b0);
        tick();
        check("to_count", to_cnt - t0, 1);

        // Byte on the limit cycle beats the timeout
        t0 = to_cnt;
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h31);
        idle(TO - 2);
        send_byte(8'h32);
        check("to_byte_wins", timeout_error, 1'b0);
        check("to_byte_busy", busy, 1'b1);
        for (int i = DL - 2; i >= 0; i--) send_byte(KD[8*i +: 8]);
        send_byte(8'h29);
        send_byte(8'hB1);
        check("to_late_fv", frame_valid, 1'b1);
        check("to_late_count", to_cnt - t0, 0);

        // Overrun in HOLD, then ack collision
        o0 = ovr_cnt;
        send_byte(8'hEE);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_fv", frame_valid, 1'b1);
        check("ovr_data", frame_data, KD);
        tick();
        check("ovr_pulse_end", overrun, 1'b0);
        byte_valid = 1'b1; byte_in = 8'h5A; frame_ack = 1'b1;
        tick();
        byte_valid = 1'b0; frame_ack = 1'b0;
        check("coll_pulse", overrun, 1'b1);
        check("coll_fv", frame_valid, 1'b0);
        check("coll_busy", busy, 1'b0);
        tick();
        check("ovr_count", ovr_cnt - o0, 2);

        // Reset mid-frame
        c0 = crc_cnt; t0 = to_cnt; o0 = ovr_cnt;
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h77);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        check("rst_outs", {frame_valid, crc_error, timeout_error, overrun, busy}, 5'b0);
        check("rst_cmd", frame_cmd, 8'h00);
        check("rst_data", frame_data, 64'h0);
        idle(2);
        check("rst_no_err", (crc_cnt - c0) + (to_cnt - t0) + (ovr_cnt - o0), 0);
        send_body(8'h31, KD, 8'h29, 0);
        send_byte(8'hB1);
        check("rst_then_fv", frame_valid, 1'b1);
        check("rst_then_data", frame_data, KD);
        do_ack();

        // Random frames with garbage, gaps and occasional CRC corruption
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(3, 0)) begin
                logic [7:0] g;
                g = 8'($urandom);
                if (g == 8'h5A) g = 8'h00;
                gap_byte(g, 4);
            end
            cmd  = 8'($urandom);
            data = {32'($urandom), 32'($urandom)};
            crc  = ref_crc(cmd, data);
            bad  = ($urandom_range(3, 0) == 0);
            if (bad) crc = crc ^ 16'($urandom_range(65535, 1));
            c0 = crc_cnt;
            send_body(cmd, data, crc[15:8], 5);
            idle($urandom_range(5, 0));
            send_byte(crc[7:0]);
            check("rnd_fv", frame_valid, !bad);
            check("rnd_crc_err", crc_error, bad);
            if (!bad) begin
                check("rnd_cmd", frame_cmd, cmd);
                check("rnd_data", frame_data, data);
                idle($urandom_range(3, 0));
                do_ack();
            end
            check("rnd_idle", busy, 1'b0);
            tick();
            check("rnd_crc_cnt", crc_cnt - c0, bad);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
